div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Iterative 32-cycle restoring divider with its sequencing controller. Serves the M-extension DIV/DIVU/REM/REMU instructions in the execute stage of the pipelined core.
- While a divide is in flight it stalls the pipeline. It handles divide-by-zero and signed overflow by early-out, and aborts cleanly on pipeline flush.
- It returns the result and destination register for write-back.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start_i  input  1  execute stage presents a divide instruction.
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- dividend_i  input  XLEN  rs1 value.
- divisor_i  input  XLEN  rs2 value.
- rd_i  input  5  destination register index.
- flush_i  input  1  pipeline flush; aborts the operation.
- stall_o  output  1  hold the pipeline (combinational).
- valid_o  output  1  result valid, single-cycle pulse.
- result_o  output  XLEN  quotient or remainder.
- rd_o  output  5  destination index for the result.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (rst=1 at clk edge): state=IDLE, counter=0, valid_o=0, result_o=0, rd_o=0. Reset overrides all other inputs, including mid-operation.
- Flush: flush_i=1 in any state sends the block to IDLE next cycle with valid_o=0 and no result. Flush beats a simultaneous start_i.
- Accepting a start (IDLE, start_i=1, flush_i=0):
  - Latch op, rd, and the operand magnitudes. For signed ops: abs(dividend), abs(divisor), neg_q = sign(a) XOR sign(b), neg_r = sign(a). For unsigned ops use raw values.
  - If divisor==0, go to DONE with special result.
  - Else if the op is signed and dividend==0x80000000 and divisor==0xFFFFFFFF, go to DONE with special result.
  - Else go to CALC, counter=0.
- CALC, one restoring step per cycle:
  - rem' = {rem, quo[MSB]}; quo shifts left.
  - If rem' >= divisor: rem' -= divisor and the new quotient LSB = 1.
  - counter increments; after step XLEN-1 (counter==XLEN-1) go to DONE.
- DONE:
  - valid_o=1 for exactly one cycle.
  - result_o = signed-corrected quotient (DIV/DIVU) or remainder (REM/REMU).
  - rd_o = latched rd.
  - Next state is IDLE unconditionally.
- Special results:
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> dividend.
  - Overflow: DIV -> 0x80000000; REM -> 0.
- stall_o = (IDLE & start_i & ~flush_i) | CALC. It is low in DONE, so the instruction advances with the result.
- Latency, counted from the start cycle edge:
  - Normal: valid_o in cycle XLEN+1 (cycle 33).
  - Special: valid_o in cycle 1.
- start_i outside IDLE is ignored. Back-to-back divides are accepted in the IDLE cycle after DONE.
- result_o and rd_o hold their last values when valid_o=0.
- Width rules: the remainder register is XLEN+1 bits to hold the compare/subtract carry. Sign correction is two's complement negation at XLEN width.

Decomposition:
- Shared package/defines file:
  - op encodings DIV/DIVU/REM/REMU.
  - state encodings IDLE/CALC/DONE.
  - constants XLEN, DIV_ZERO_Q (all ones), OVF_Q (0x80000000).
- One sub-module: div_restore_step, combinational single iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: rem_next, quo_next.
  - Instantiated once in CALC.
- FSM, counter, sign handling and special cases stay in div_ctrl.

Test Plan:
- DIVU 100/7, rd=5 -> stall_o high cycles 0–32; valid_o pulse at cycle 33 with result_o=14, rd_o=5. REMU same operands -> 2.
- DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). REM 7/-2 -> 1.
- DIV 5/0 -> valid_o at cycle 1, result 0xFFFFFFFF. REMU 5/0 -> 5. stall_o high only in cycle 0.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1. REM same -> 0. DIVU same operands -> normal 33-cycle path, result 0.
- flush_i at cycle 10 of CALC -> IDLE at cycle 11, no valid_o. A new DIVU 9/3 started in cycle 11 -> 3 at cycle 44.
- rst at cycle 20 mid-CALC -> all outputs 0, IDLE. start_i toggled during CALC is ignored and the original result is unchanged.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared encodings and constants for the iterative divider.
package div_ctrl_pkg;

   localparam int XLEN = 32;

   // Result for a quotient when the divisor is zero.
   localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
   // Result for a signed quotient that overflows (most negative / -1).
   localparam logic [XLEN-1:0] OVF_Q = 32'h8000_0000;

   // funct3[1:0] of the M-extension divide group.
   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_e;

   // Bit 0 clear means the operation treats its operands as signed.
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   // Bit 1 set selects the remainder instead of the quotient.
   function automatic logic op_is_rem(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when it fits.
module div_restore_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN:0]   rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN:0]   rem_next,
   output logic [XLEN-1:0] quo_next
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;
   // The partial remainder is always below the divisor, so its top bit is
   // zero on entry; only the extra bit produced by the shift matters.
   logic          rem_top_unused;

   assign rem_top_unused = rem[XLEN];
   assign shifted        = {rem[XLEN-1:0], quo[XLEN-1]};
   assign diff           = shifted - {1'b0, divisor};

   // Compare/subtract and shift the new quotient bit in from the right.
   always_comb begin
      rem_next = shifted;
      quo_next = {quo[XLEN-2:0], 1'b0};
      if (shifted >= {1'b0, divisor}) begin
         rem_next = diff;
         quo_next = {quo[XLEN-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// Execute-stage divide unit: sequences a 32-step restoring divide, handles
// divide-by-zero and signed overflow by early-out, and aborts on flush.
// Handshake: the pipeline holds while stall_o is high; a result is
// delivered as a one-cycle valid_o pulse with result_o/rd_o, which then
// hold their values until the next result or reset.
module div_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic [4:0]      rd_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);

   import div_ctrl_pkg::*;

   div_state_e      state;
   div_state_e      state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [1:0]      op_q;
   logic [4:0]      rd_q;
   logic [XLEN:0]   rem_q;
   logic [XLEN-1:0] quo_q;
   logic [XLEN-1:0] dvsr_q;
   logic            neg_q;
   logic            neg_r;

   logic [XLEN:0]   rem_nxt;
   logic [XLEN-1:0] quo_nxt;

   logic            accept;
   logic            is_signed;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic            div_zero;
   logic            ovf;
   logic            special;
   logic [XLEN-1:0] special_res;
   logic            last_step;
   logic [XLEN-1:0] quo_fix;
   logic [XLEN-1:0] rem_fix;
   logic [XLEN-1:0] calc_res;

   assign accept    = (state == IDLE) && start_i && !flush_i;
   assign is_signed = op_is_signed(op_i);
   assign a_neg     = is_signed && dividend_i[XLEN-1];
   assign b_neg     = is_signed && divisor_i[XLEN-1];
   assign a_mag     = a_neg ? (-dividend_i) : dividend_i;
   assign b_mag     = b_neg ? (-divisor_i) : divisor_i;

   assign div_zero  = (divisor_i == '0);
   assign ovf       = is_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                      && (divisor_i == '1);
   assign special   = div_zero || ovf;
   assign special_res = div_zero ? (op_is_rem(op_i) ? dividend_i : '1)
                                 : (op_is_rem(op_i) ? '0 : {1'b1, {(XLEN-1){1'b0}}});

   assign last_step = (cnt == CNT_W'(XLEN - 1));
   assign quo_fix   = neg_q ? (-quo_nxt) : quo_nxt;
   assign rem_fix   = neg_r ? (-rem_nxt[XLEN-1:0]) : rem_nxt[XLEN-1:0];
   assign calc_res  = op_is_rem(op_q) ? rem_fix : quo_fix;

   assign stall_o   = accept || (state == CALC);
   assign valid_o   = (state == DONE);

   div_restore_step #(.XLEN(XLEN)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dvsr_q),
      .rem_next (rem_nxt),
      .quo_next (quo_nxt)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; a flush always wins and returns to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = special ? DONE : CALC;
         CALC: if (last_step) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush_i) state_nxt = IDLE;
   end

   // Operand capture, iteration datapath and result/rd registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         op_q     <= '0;
         rd_q     <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= '0;
         rd_o     <= '0;
      end else if (accept) begin
         op_q   <= op_i;
         rd_q   <= rd_i;
         rem_q  <= '0;
         quo_q  <= a_mag;
         dvsr_q <= b_mag;
         neg_q  <= a_neg ^ b_neg;
         neg_r  <= a_neg;
         cnt    <= '0;
         if (special) begin
            result_o <= special_res;
            rd_o     <= rd_i;
         end
      end else if ((state == CALC) && !flush_i) begin
         rem_q <= rem_nxt;
         quo_q <= quo_nxt;
         cnt   <= cnt + CNT_W'(1);
         if (last_step) begin
            result_o <= calc_res;
            rd_o     <= rd_q;
         end
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed divides, special cases,
// flush, mid-operation reset and start_i noise during a calculation.
module tb_div_ctrl;

   import div_ctrl_pkg::*;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic [4:0]  rd_i;
   logic        flush_i;
   logic        stall_o;
   logic        valid_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;

   div_ctrl #(.XLEN(32), .CNT_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .op_i       (op_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .rd_i       (rd_i),
      .flush_i    (flush_i),
      .stall_o    (stall_o),
      .valid_o    (valid_o),
      .result_o   (result_o),
      .rd_o       (rd_o)
   );

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Hand-computed expectations (written by the driver only).
   logic [31:0] exp_q[$];
   logic [4:0]  exp_rd_q[$];
   int          exp_cyc_q[$];

   logic chk_en  = 1'b0;
   logic tb_done = 1'b0;
   logic fin_chk = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, got, want);
   endtask

   // Arithmetic reference for one divide instruction.
   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] r;
      if (b == 32'd0) r = op[1] ? a : DIV_ZERO_Q;
      else if (!op[0] && a == OVF_Q && b == 32'hFFFF_FFFF) r = op[1] ? 32'd0 : OVF_Q;
      else begin
         case (op)
            2'b00:   r = $signed(a) / $signed(b);
            2'b01:   r = a / b;
            2'b10:   r = $signed(a) % $signed(b);
            default: r = a % b;
         endcase
      end
      return r;
   endfunction

   function automatic logic ref_special(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
      return (b == 32'd0) || (!op[0] && a == OVF_Q && b == 32'hFFFF_FFFF);
   endfunction

   // Compare process: cycle-level model of the unit plus scoreboard.
   logic        m_active = 1'b0;
   int          m_end    = 0;
   int          m_done   = 0;
   logic [31:0] m_res    = '0;
   logic [4:0]  m_rd     = '0;
   logic [31:0] m_last_res = '0;
   logic [4:0]  m_last_rd  = '0;
   int          rd_ptr   = 0;

   initial begin
      logic exp_v;
      logic exp_s;
      logic was_active;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            exp_v = m_active && (cyc == m_done);
            exp_s = m_active ? (cyc <= m_end) : (start_i && !flush_i);
            chk("stall", 32'(stall_o), 32'(exp_s));
            chk("valid", 32'(valid_o), 32'(exp_v));
            if (exp_v) begin
               chk("result", result_o, m_res);
               chk("rd", 32'(rd_o), 32'(m_rd));
            end else begin
               chk("hold_result", result_o, m_last_res);
               chk("hold_rd", 32'(rd_o), 32'(m_last_rd));
            end
            if (valid_o) begin
               if (rd_ptr < exp_q.size()) begin
                  chk("lit_result", result_o, exp_q[rd_ptr]);
                  chk("lit_model", m_res, exp_q[rd_ptr]);
                  chk("lit_rd", 32'(rd_o), 32'(exp_rd_q[rd_ptr]));
                  chk("lit_latency", 32'(cyc), 32'(exp_cyc_q[rd_ptr]));
                  rd_ptr++;
               end else begin
                  n_chk++;
                  $display("FAIL spurious_valid at cycle %0d: got valid_o=1, want 0", cyc);
               end
            end
            if (tb_done && !fin_chk) begin
               chk("results_delivered", 32'(rd_ptr), 32'(exp_q.size()));
               fin_chk = 1'b1;
            end
            // Advance the model with the inputs seen this cycle.
            was_active = m_active;
            if (m_active && cyc >= m_done) m_active = 1'b0;
            if (exp_v) begin
               m_last_res = m_res;
               m_last_rd  = m_rd;
            end
            if (m_active && flush_i) m_active = 1'b0;
            if (!was_active && start_i && !flush_i && !rst) begin
               m_active = 1'b1;
               m_res    = ref_div(op_i, dividend_i, divisor_i);
               m_rd     = rd_i;
               if (ref_special(op_i, dividend_i, divisor_i)) begin
                  m_end  = cyc;
                  m_done = cyc + 1;
               end else begin
                  m_end  = cyc + 32;
                  m_done = cyc + 33;
               end
            end
            if (rst) begin
               m_active   = 1'b0;
               m_last_res = '0;
               m_last_rd  = '0;
            end
         end
      end
   end

   // Driver tasks.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_start(input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd);
      start_i    = 1'b1;
      op_i       = op;
      dividend_i = a;
      divisor_i  = b;
      rd_i       = rd;
      step();
      start_i = 1'b0;
   endtask

   task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] lit, input int lat);
      exp_q.push_back(lit);
      exp_rd_q.push_back(rd);
      exp_cyc_q.push_back(cyc + lat);
      drive_start(op, a, b, rd);
      repeat (lat) step();
   endtask

   initial begin
      rst        = 1'b1;
      start_i    = 1'b0;
      op_i       = '0;
      dividend_i = '0;
      divisor_i  = '0;
      rd_i       = '0;
      flush_i    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      repeat (2) step();

      // Normal path, back to back.
      run(DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33);
      run(REMU, 32'd100, 32'd7, 5'd6, 32'd2, 33);
      run(DIV,  32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33);
      run(REM,  32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
      run(REM,  32'd7, 32'hFFFF_FFFE, 5'd9, 32'd1, 33);
      run(REMU, 32'hFFFF_FFFF, 32'h10, 5'd10, 32'hF, 33);
      run(DIVU, 32'hFFFF_FFFF, 32'd1, 5'd11, 32'hFFFF_FFFF, 33);

      // Early-out cases.
      run(DIV,  32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
      run(REMU, 32'd5, 32'd0, 5'd13, 32'd5, 1);
      run(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1);
      run(REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1);
      run(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 33);
      step();

      // Flush ten cycles into the calculation, then restart at once.
      drive_start(DIVU, 32'd1000, 32'd7, 5'd3);
      repeat (9) step();
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      run(DIVU, 32'd9, 32'd3, 5'd4, 32'd3, 33);
      step();

      // Reset in the middle of a calculation.
      drive_start(DIVU, 32'd1000, 32'd7, 5'd20);
      repeat (19) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (3) step();

      // start_i noise during a calculation must not disturb it.
      exp_q.push_back(32'hFFFF_FEB3);
      exp_rd_q.push_back(5'd21);
      exp_cyc_q.push_back(cyc + 33);
      drive_start(DIV, 32'd1000, 32'hFFFF_FFFD, 5'd21);
      for (int n = 0; n < 33; n++) begin
         start_i    = (n < 25) && (n % 2 == 0);
         op_i       = 2'($urandom_range(0, 3));
         dividend_i = $urandom;
         divisor_i  = $urandom;
         rd_i       = 5'($urandom_range(0, 31));
         step();
      end
      start_i = 1'b0;
      repeat (2) step();

      tb_done = 1'b1;
      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
